// File: rtl/spi_slave_pkg.sv
// Shared types and field constants for the multi-frame SPI slave.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CFG,
        ST_WAIT_IDLE
    } state_e;

    // Inbound data frame: {valid, data[127:0], encrypt, is_key}
    localparam int unsigned AES_IS_KEY_BIT  = 0;
    localparam int unsigned AES_ENCRYPT_BIT = 1;
    localparam int unsigned AES_DATA_LSB    = 2;
    localparam int unsigned AES_DATA_MSB    = 129;
    localparam int unsigned AES_VALID_BIT   = 130;

    // Return frame: {valid, data[127:0], encrypt}
    localparam int unsigned RET_ENCRYPT_BIT = 0;
    localparam int unsigned RET_DATA_LSB    = 1;
    localparam int unsigned RET_DATA_MSB    = 128;
    localparam int unsigned RET_VALID_BIT   = 129;

    // Regulator config word slices
    localparam int unsigned CFG_P_MSB = 11;
    localparam int unsigned CFG_P_LSB = 8;
    localparam int unsigned CFG_I_MSB = 7;
    localparam int unsigned CFG_I_LSB = 4;
    localparam int unsigned CFG_D_MSB = 3;
    localparam int unsigned CFG_D_LSB = 0;

endpackage

// File: rtl/spi_shift_channel.sv
// Per-channel rx/tx shifter: receives LEN bits and returns a TX_W-bit word,
// in either bit order. The counter is owned by the caller.
module spi_shift_channel
    import spi_slave_pkg::*;
#(
    parameter int unsigned LEN       = 12,
    parameter int unsigned TX_W      = 12,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             shift,
    input  logic             mosi,
    input  logic [CNT_W-1:0] cnt,
    input  logic [TX_W-1:0]  tx_word,
    output logic [LEN-1:0]   rx_data,
    output logic             tx_bit,
    output logic             exhausted
);

    logic [LEN-1:0]  rx_q, rx_d;
    logic [TX_W-1:0] tx_q, tx_d, tx_src;
    logic            rx_en;

    assign exhausted = (cnt >= CNT_W'(TX_W));
    assign rx_en     = start || (shift && (cnt < CNT_W'(LEN)));
    assign rx_data   = rx_q;

    // On the start edge the first return bit comes straight from the load word.
    always_comb begin
        tx_src = start ? tx_word : tx_q;
        tx_bit = MSB_FIRST ? tx_src[TX_W-1] : tx_src[0];
        rx_d   = rx_q;
        tx_d   = tx_q;
        if (rx_en) begin
            rx_d = MSB_FIRST ? {rx_q[LEN-2:0], mosi} : {mosi, rx_q[LEN-1:1]};
        end
        if (start || shift) begin
            tx_d = MSB_FIRST ? {tx_src[TX_W-2:0], 1'b0} : {1'b0, tx_src[TX_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q <= '0;
            tx_q <= '0;
        end else begin
            rx_q <= rx_d;
            tx_q <= tx_d;
        end
    end

endmodule

// File: rtl/spi_multi_frame_slave.sv
// Two-channel SPI slave (data + config) on sclk with length check,
// atomic commit, return-word handshake, config readback and error pulses.
module spi_multi_frame_slave
    import spi_slave_pkg::*;
#(
    parameter int unsigned       DIN_W          = 131,
    parameter int unsigned       DOUT_W         = 130,
    parameter int unsigned       CFG_W          = 12,
    parameter logic [CFG_W-1:0]  CFG_RST        = '0,
    parameter bit                DATA_MSB_FIRST = 1'b1,
    parameter int unsigned       CNT_W          = $clog2(DIN_W + 2)
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              mosi,
    input  logic              csel_data,
    input  logic              csel_cfg,
    output logic              miso,
    output logic [DIN_W-1:0]  din,
    output logic              din_valid,
    input  logic [DOUT_W-1:0] ret_word,
    input  logic              ret_valid,
    output logic              sent,
    output logic [CFG_W-1:0]  cfg_out,
    output logic              cfg_update,
    output logic              frame_err,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               loaded_q, loaded_d;
    logic               armed_q, armed_d;
    logic               miso_q, miso_d;
    logic [DIN_W-1:0]   din_q, din_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic               din_valid_q, din_valid_d;
    logic               sent_q, sent_d;
    logic               cfg_update_q, cfg_update_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;

    logic               start_data, start_cfg, shift_data, shift_cfg;
    logic [DIN_W-1:0]   data_rx;
    logic [CFG_W-1:0]   cfg_rx;
    logic               data_bit, cfg_bit, data_exh, cfg_exh;

    spi_shift_channel #(
        .LEN       (DIN_W),
        .TX_W      (DOUT_W),
        .MSB_FIRST (DATA_MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_data (
        .clk       (sclk),
        .reset     (reset),
        .start     (start_data),
        .shift     (shift_data),
        .mosi      (mosi),
        .cnt       (cnt_q),
        .tx_word   (ret_valid ? ret_word : '0),
        .rx_data   (data_rx),
        .tx_bit    (data_bit),
        .exhausted (data_exh)
    );

    spi_shift_channel #(
        .LEN       (CFG_W),
        .TX_W      (CFG_W),
        .MSB_FIRST (1'b1),
        .CNT_W     (CNT_W)
    ) u_cfg (
        .clk       (sclk),
        .reset     (reset),
        .start     (start_cfg),
        .shift     (shift_cfg),
        .mosi      (mosi),
        .cnt       (cnt_q),
        .tx_word   (cfg_q),
        .rx_data   (cfg_rx),
        .tx_bit    (cfg_bit),
        .exhausted (cfg_exh)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        loaded_d     = loaded_q;
        // A select held high since reset must drop before any frame may start.
        armed_d      = armed_q | (!csel_data && !csel_cfg);
        miso_d       = 1'b0;
        din_d        = din_q;
        cfg_d        = cfg_q;
        din_valid_d  = 1'b0;
        sent_d       = 1'b0;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;
        start_data   = 1'b0;
        start_cfg    = 1'b0;
        shift_data   = 1'b0;
        shift_cfg    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (csel_data && csel_cfg) begin
                    state_d = ST_WAIT_IDLE;
                end else if (armed_q && csel_data) begin
                    state_d    = ST_DATA;
                    cnt_d      = CNT_W'(1);
                    start_data = 1'b1;
                    loaded_d   = ret_valid;
                    miso_d     = data_bit;
                end else if (armed_q && csel_cfg) begin
                    state_d   = ST_CFG;
                    cnt_d     = CNT_W'(1);
                    start_cfg = 1'b1;
                    miso_d    = cfg_bit;
                end
            end
            ST_DATA: begin
                if (csel_cfg) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_IDLE;
                    cnt_d       = '0;
                end else if (csel_data) begin
                    shift_data = 1'b1;
                    miso_d     = data_exh ? 1'b0 : data_bit;
                    if (cnt_q != CNT_W'(DIN_W + 1)) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (cnt_q == CNT_W'(DIN_W)) begin
                        din_d       = data_rx;
                        din_valid_d = 1'b1;
                        sent_d      = loaded_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_CFG: begin
                if (csel_data) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_IDLE;
                    cnt_d       = '0;
                end else if (csel_cfg) begin
                    shift_cfg = 1'b1;
                    miso_d    = cfg_exh ? 1'b0 : cfg_bit;
                    if (cnt_q != CNT_W'(CFG_W + 1)) cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    if (cnt_q == CNT_W'(CFG_W)) begin
                        cfg_d        = cfg_rx;
                        cfg_update_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_IDLE: begin
                if (!csel_data && !csel_cfg) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            loaded_q     <= 1'b0;
            armed_q      <= 1'b0;
            miso_q       <= 1'b0;
            din_q        <= '0;
            cfg_q        <= CFG_RST;
            din_valid_q  <= 1'b0;
            sent_q       <= 1'b0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loaded_q     <= loaded_d;
            armed_q      <= armed_d;
            miso_q       <= miso_d;
            din_q        <= din_d;
            cfg_q        <= cfg_d;
            din_valid_q  <= din_valid_d;
            sent_q       <= sent_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign miso       = miso_q;
    assign din        = din_q;
    assign cfg_out    = cfg_q;
    assign din_valid  = din_valid_q;
    assign sent       = sent_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_multi_frame_slave.sv
// Self-checking bench for spi_multi_frame_slave: config table, data frames,
// length errors, abort, mid-frame reset; commit pulses checked via scoreboard.
module tb_spi_multi_frame_slave;
    import spi_slave_pkg::*;

    localparam int unsigned DIN_W  = 131;
    localparam int unsigned DOUT_W = 130;
    localparam int unsigned CFG_W  = 12;
    localparam int K_DATA = 0;
    localparam int K_CFG  = 1;
    localparam int K_ERR  = 2;

    logic              sclk = 1'b0;
    logic              reset, mosi, csel_data, csel_cfg, ret_valid;
    logic [DOUT_W-1:0] ret_word;
    logic              miso, din_valid, sent, cfg_update, frame_err, busy;
    logic [DIN_W-1:0]  din;
    logic [CFG_W-1:0]  cfg_out;

    spi_multi_frame_slave #(
        .DIN_W   (DIN_W),
        .DOUT_W  (DOUT_W),
        .CFG_W   (CFG_W),
        .CFG_RST (12'h000)
    ) dut (
        .sclk       (sclk),
        .reset      (reset),
        .mosi       (mosi),
        .csel_data  (csel_data),
        .csel_cfg   (csel_cfg),
        .miso       (miso),
        .din        (din),
        .din_valid  (din_valid),
        .ret_word   (ret_word),
        .ret_valid  (ret_valid),
        .sent       (sent),
        .cfg_out    (cfg_out),
        .cfg_update (cfg_update),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        int               kind;
        logic             sent;
        logic [DIN_W-1:0] din;
        logic [CFG_W-1:0] cfg;
    } ev_t;

    typedef struct {
        logic [CFG_W-1:0] w;
        logic [CFG_W-1:0] rb;
    } cfg_vec_t;

    ev_t              sb[$];
    int               total = 0;
    int               bad   = 0;
    logic [DIN_W-1:0] m_din;
    logic [CFG_W-1:0] m_cfg;

    task automatic chk(input string name, input logic [DIN_W-1:0] act, input logic [DIN_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic s, input logic [DIN_W-1:0] d, input logic [CFG_W-1:0] c);
        ev_t e;
        e.kind = k;
        e.sent = s;
        e.din  = d;
        e.cfg  = c;
        sb.push_back(e);
    endtask

    // Every pulse on the commit/error outputs must match the oldest expectation.
    always @(posedge sclk) begin
        ev_t e;
        #1;
        if (din_valid || cfg_update || frame_err || sent) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: dv=%b cu=%b fe=%b sent=%b, none expected",
                         din_valid, cfg_update, frame_err, sent);
            end else begin
                e = sb.pop_front();
                chk("ev_din_valid", din_valid, e.kind == K_DATA);
                chk("ev_cfg_update", cfg_update, e.kind == K_CFG);
                chk("ev_frame_err", frame_err, e.kind == K_ERR);
                chk("ev_sent", sent, e.sent);
                chk("ev_din", din, e.din);
                chk("ev_cfg_out", cfg_out, e.cfg);
            end
        end
    end

    task automatic step(input logic cd, input logic cc, input logic b);
        @(negedge sclk);
        csel_data = cd;
        csel_cfg  = cc;
        mosi      = b;
        @(posedge sclk);
        #2;
    endtask

    task automatic send_cfg(input logic [CFG_W-1:0] w, output logic [CFG_W-1:0] rb);
        rb = '0;
        for (int i = CFG_W - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i]);
            rb = {rb[CFG_W-2:0], miso};
        end
        expect_ev(K_CFG, 1'b0, m_din, w);
        m_cfg = w;
        step(1'b0, 1'b0, 1'b0);
        chk("cfg_commit_seen", sb.size(), 0);
        chk("cfg_out", cfg_out, m_cfg);
        chk("cfg_busy_after", busy, 1'b0);
    endtask

    task automatic send_data(input int n, input logic [DIN_W-1:0] w, input logic rv,
                             input logic [DOUT_W-1:0] rw, output logic [DOUT_W-1:0] cap);
        logic b;
        ret_word  = rw;
        ret_valid = rv;
        cap       = '0;
        for (int i = 0; i < n; i++) begin
            b = 1'b1;
            if (i < DIN_W) b = w[DIN_W-1-i];
            step(1'b1, 1'b0, b);
            if (i < DOUT_W) cap = {cap[DOUT_W-2:0], miso};
            if (i == DOUT_W) chk("miso_exhausted", miso, 1'b0);
            if (i == 60) begin
                chk("busy_mid_frame", busy, 1'b1);
                chk("din_held_mid_frame", din, m_din);
            end
        end
        if (n == DIN_W) begin
            expect_ev(K_DATA, rv, w, m_cfg);
            m_din = w;
        end else begin
            expect_ev(K_ERR, 1'b0, m_din, m_cfg);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("data_commit_seen", sb.size(), 0);
        chk("din", din, m_din);
        chk("miso_after_frame", miso, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the test completed");
        $fatal(1);
    end

    initial begin
        cfg_vec_t          cv[4];
        logic [CFG_W-1:0]  rb;
        logic [DOUT_W-1:0] cap;
        logic [DOUT_W-1:0] rw1, rw2;
        logic [DIN_W-1:0]  w1, w2, w3;

        cv[0] = '{w: 12'hfab, rb: 12'h000};
        cv[1] = '{w: 12'h123, rb: 12'hfab};
        cv[2] = '{w: 12'hfff, rb: 12'h123};
        cv[3] = '{w: 12'h5a0, rb: 12'hfff};
        rw1 = 130'h3_dead_abcd_beed_ffff_beef_dead_dead_beef;
        rw2 = 130'h2_0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
        w1  = {1'b1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1, 1'b0};
        w2  = {1'b0, 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100, 1'b0, 1'b1};
        w3  = {1'b1, 128'hcafe_f00d_1234_5678_9abc_def0_aa55_33cc, 1'b1, 1'b1};

        reset = 1'b1; mosi = 1'b0; csel_data = 1'b0; csel_cfg = 1'b0;
        ret_valid = 1'b0; ret_word = '0;
        m_din = '0; m_cfg = 12'h000;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_din", din, '0);
        chk("rst_cfg_out", cfg_out, 12'h000);
        chk("rst_miso", miso, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge sclk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            send_cfg(cv[i].w, rb);
            chk("cfg_readback", rb, cv[i].rb);
            if (cv[i].w == 12'hfab) begin
                chk("cfg_p", cfg_out[CFG_P_MSB:CFG_P_LSB], 4'hf);
                chk("cfg_i", cfg_out[CFG_I_MSB:CFG_I_LSB], 4'ha);
                chk("cfg_d", cfg_out[CFG_D_MSB:CFG_D_LSB], 4'hb);
            end
        end

        send_data(DIN_W, w1, 1'b1, rw1, cap);
        chk("ret_word_on_miso", cap, rw1);
        chk("din_valid_field", din[AES_VALID_BIT], 1'b1);
        chk("din_is_key_field", din[AES_IS_KEY_BIT], 1'b0);

        send_data(DIN_W, w2, 1'b0, rw1, cap);
        chk("miso_zero_no_ret", cap, '0);

        send_data(100, w1, 1'b1, rw2, cap);
        send_data(140, w1, 1'b1, rw2, cap);
        chk("din_kept_after_len_err", din, w2);

        ret_valid = 1'b1;
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, w3[DIN_W-1-i]);
        expect_ev(K_ERR, 1'b0, m_din, m_cfg);
        step(1'b1, 1'b1, 1'b0);
        chk("abort_err_seen", sb.size(), 0);
        chk("abort_busy0", busy, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("abort_busy1", busy, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("abort_busy2", busy, 1'b1);
        chk("abort_miso", miso, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_busy_released", busy, 1'b0);
        chk("abort_din_kept", din, w2);
        send_cfg(12'h9c3, rb);
        chk("cfg_readback_after_abort", rb, 12'h5a0);

        ret_word = rw2;
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, w3[DIN_W-1-i]);
        @(negedge sclk);
        reset = 1'b1;
        @(posedge sclk);
        #2;
        m_din = '0;
        m_cfg = 12'h000;
        chk("mid_rst_din", din, '0);
        chk("mid_rst_cfg_out", cfg_out, 12'h000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_miso", miso, 1'b0);
        @(negedge sclk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("held_sel_no_start", busy, 1'b0);
            chk("held_sel_miso", miso, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        send_data(DIN_W, w3, 1'b1, rw2, cap);
        chk("ret_word_after_reset", cap, rw2);

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
